// File: rtl/pattern_detector_pkg.sv
// Shared types, constants and helpers for the serial pattern detector.
// Holds the match mode enum, length-width helper and reset configuration.
package pattern_detector_pkg;

  typedef enum logic [1:0] {
    MODE_OVERLAP = 2'b00,
    MODE_RESTART = 2'b01,
    MODE_ONESHOT = 2'b10
  } match_mode_t;

  localparam int          RST_LEN  = 5;
  localparam match_mode_t RST_MODE = MODE_RESTART;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // The unused encoding 2'b11 behaves like restart.
  function automatic match_mode_t to_mode(input logic [1:0] m);
    match_mode_t r;
    unique case (m)
      2'b00:   r = MODE_OVERLAP;
      2'b10:   r = MODE_ONESHOT;
      default: r = MODE_RESTART;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Ports: clk, rst, clr, inc, count[W-1:0].
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pattern_detector.sv
// Programmable serial bit-pattern detector with overlap/restart/one-shot modes.
// Ports: clk, rst, cfg_we/pattern/len/mode, in_valid, in_bit -> match, armed, match_count, cfg_err.
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter  int MAX_LEN = 16,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [1:0]         cfg_mode,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               match,
  output logic               armed,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] MAXL = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist, hist_d, hist_nx;
  logic [MAX_LEN-1:0] pattern, pattern_d;
  logic [MAX_LEN-1:0] mask, ones;
  logic [LEN_W-1:0]   fill, fill_d, fill_nx;
  logic [LEN_W-1:0]   len, len_d;
  match_mode_t        mode, mode_d;
  logic               armed_d, match_d, err_d;
  logic               cfg_ok, cfg_bad, accept, hit;

  // Oldest history bit shifts out and never takes part in a compare.
  logic unused_msb;
  assign unused_msb = hist[MAX_LEN-1];

  assign cfg_ok  = cfg_we && (cfg_len != '0) && (cfg_len <= MAXL);
  assign cfg_bad = cfg_we && !cfg_ok;
  assign accept  = in_valid && armed && !cfg_we;

  assign hist_nx = {hist[MAX_LEN-2:0], in_bit};
  assign fill_nx = (fill == MAXL) ? fill : fill + LEN_W'(1);

  // Equivalent to (1 << len) - 1, but also correct for len == MAX_LEN.
  assign ones = '1;
  assign mask = ~(ones << len);

  assign hit = accept && (fill_nx >= len) &&
               (((hist_nx ^ pattern) & mask) == '0);

  always_comb begin
    hist_d    = hist;
    pattern_d = pattern;
    len_d     = len;
    mode_d    = mode;
    fill_d    = fill;
    armed_d   = armed;
    match_d   = 1'b0;
    err_d     = 1'b0;
    unique case (1'b1)
      cfg_ok: begin
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        mode_d    = to_mode(cfg_mode);
        fill_d    = '0;
        armed_d   = 1'b1;
      end
      cfg_bad: begin
        err_d = 1'b1;
      end
      accept: begin
        hist_d  = hist_nx;
        fill_d  = fill_nx;
        match_d = hit;
        if (hit) begin
          unique case (mode)
            MODE_OVERLAP: ;
            MODE_ONESHOT: begin
              fill_d  = '0;
              armed_d = 1'b0;
            end
            default: fill_d = '0;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist    <= '0;
      pattern <= '1;
      len     <= LEN_W'(RST_LEN);
      mode    <= RST_MODE;
      fill    <= '0;
      armed   <= 1'b1;
      match   <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      hist    <= hist_d;
      pattern <= pattern_d;
      len     <= len_d;
      mode    <= mode_d;
      fill    <= fill_d;
      armed   <= armed_d;
      match   <= match_d;
      cfg_err <= err_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cfg_ok),
    .inc  (hit),
    .count(match_count)
  );

endmodule

// File: tb/tb_pattern_detector.sv
// Directed self-checking bench for pattern_detector.
// Uses MAX_LEN=16 and a 2-bit counter so saturation is reachable.
module tb_pattern_detector;
  import pattern_detector_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [15:0] cfg_pattern;
  logic [4:0]  cfg_len;
  logic [1:0]  cfg_mode;
  logic        in_valid;
  logic        in_bit;
  logic        match;
  logic        armed;
  logic [1:0]  match_count;
  logic        cfg_err;

  int checks = 0;
  int fails  = 0;

  pattern_detector #(
    .MAX_LEN(16),
    .CNT_W  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_mode   (cfg_mode),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .match      (match),
    .armed      (armed),
    .match_count(match_count),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic cfg(input logic [15:0] p, input logic [4:0] l,
                     input logic [1:0] m);
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_mode    = m;
    tick();
    cfg_we = 1'b0;
  endtask

  // Sends up to 16 bits (MSB of the n-bit field first), collecting match.
  task automatic burst(input logic [15:0] bits, input int n,
                       output logic [15:0] m);
    m = '0;
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i]);
      m = {m[14:0], match};
    end
  endtask

  logic [15:0] m;

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_mode = 2'b00; in_valid = 1'b0; in_bit = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_armed", 32'(armed), 32'd1);
    chk("rst_count", 32'(match_count), 32'd0);
    chk("rst_err",   32'(cfg_err), 32'd0);

    // Legacy five-ones detector, restart after match.
    burst(16'h001f, 5, m);
    chk("def_m5", 32'(m[4:0]), 32'b00001);
    chk("def_cnt1", 32'(match_count), 32'd1);
    burst(16'h001f, 5, m);
    chk("def_m10", 32'(m[4:0]), 32'b00001);
    chk("def_cnt2", 32'(match_count), 32'd2);

    // Reset drops a partial pattern.
    burst(16'h0007, 3, m);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_cnt", 32'(match_count), 32'd0);
    burst(16'h001f, 5, m);
    chk("mid_rst_m", 32'(m[4:0]), 32'b00001);

    // Overlap vs restart on 10101 against 101.
    cfg(16'b101, 5'd3, MODE_OVERLAP);
    chk("ovl_err", 32'(cfg_err), 32'd0);
    chk("ovl_cnt0", 32'(match_count), 32'd0);
    burst(16'b10101, 5, m);
    chk("ovl_m", 32'(m[4:0]), 32'b00101);
    chk("ovl_cnt", 32'(match_count), 32'd2);
    cfg(16'b101, 5'd3, MODE_RESTART);
    burst(16'b10101, 5, m);
    chk("rst_m", 32'(m[4:0]), 32'b00100);
    chk("rst_cnt", 32'(match_count), 32'd1);

    // One-shot disarms until the next valid config.
    cfg(16'b1100, 5'd4, MODE_ONESHOT);
    burst(16'b11001100, 8, m);
    chk("one_m", 32'(m[7:0]), 32'b00010000);
    chk("one_armed", 32'(armed), 32'd0);
    chk("one_cnt", 32'(match_count), 32'd1);
    cfg(16'b1100, 5'd4, MODE_ONESHOT);
    chk("one_rearm", 32'(armed), 32'd1);
    chk("one_clr", 32'(match_count), 32'd0);

    // Gaps between accepted bits are ignored.
    cfg(16'b101, 5'd3, MODE_RESTART);
    send(1'b1); chk("gap_m1", 32'(match), 32'd0);
    tick();
    send(1'b0); chk("gap_m2", 32'(match), 32'd0);
    tick();
    send(1'b1); chk("gap_m3", 32'(match), 32'd1);
    tick();     chk("gap_idle", 32'(match), 32'd0);
    chk("gap_cnt", 32'(match_count), 32'd1);

    // Config write collides with the completing bit.
    cfg(16'b101, 5'd3, MODE_RESTART);
    send(1'b1); send(1'b0);
    cfg_we = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    chk("col_m", 32'(match), 32'd0);
    chk("col_cnt", 32'(match_count), 32'd0);

    // Rejected configs change nothing.
    burst(16'b101, 3, m);
    chk("bad_pre", 32'(match_count), 32'd1);
    cfg(16'hffff, 5'd0, MODE_ONESHOT);
    chk("bad0_err", 32'(cfg_err), 32'd1);
    tick();
    chk("bad0_pulse", 32'(cfg_err), 32'd0);
    cfg(16'hffff, 5'd17, MODE_ONESHOT);
    chk("bad17_err", 32'(cfg_err), 32'd1);
    chk("bad_cnt", 32'(match_count), 32'd1);
    burst(16'b101101, 6, m);
    chk("bad_m", 32'(m[5:0]), 32'b001001);
    chk("bad_armed", 32'(armed), 32'd1);
    chk("bad_cnt2", 32'(match_count), 32'd3);

    // Full-length alternating pattern.
    cfg(16'haaaa, 5'd16, MODE_RESTART);
    chk("full_err", 32'(cfg_err), 32'd0);
    burst(16'haaaa, 16, m);
    chk("full_m", 32'(m), 32'h0001);
    chk("full_cnt", 32'(match_count), 32'd1);

    // Saturating counter with back-to-back hits.
    cfg(16'b1, 5'd1, MODE_OVERLAP);
    for (int i = 1; i <= 6; i++) begin
      send(1'b1);
      chk($sformatf("sat_m%0d", i), 32'(match), 32'd1);
      chk($sformatf("sat_c%0d", i), 32'(match_count),
          32'((i > 3) ? 3 : i));
    end
    tick();
    chk("sat_end_m", 32'(match), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/pattern_detector.md
# pattern_detector

Programmable serial bit-pattern detector with a runtime-loaded pattern of 1..MAX_LEN bits, three match modes (overlapping, restart-after-match, one-shot) and a saturating match counter. It replaces the fixed five-ones detector in the serial-input front end. It consumes one qualified bit per cycle and raises a registered single-cycle match pulse. Its reset configuration is the legacy behaviour: five consecutive 1s, restart after match.

## Interface
- MAX_LEN, default 16: maximum pattern length in bits, 2..32.
- CNT_W, default 8: match counter width.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- cfg_we  input  1  load pattern, length and mode this cycle.
- cfg_pattern  input  MAX_LEN  pattern bits; bit [cfg_len-1] is the first bit received, bit [0] the last.
- cfg_len  input  LEN_W  pattern length; LEN_W = $clog2(MAX_LEN+1).
- cfg_mode  input  2  match_mode_t: MODE_OVERLAP, MODE_RESTART, MODE_ONESHOT.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  serial data bit.
- match  output  1  one-cycle pulse; the pattern completed on the previous accepted bit.
- armed  output  1  detection enabled; low only after a MODE_ONESHOT hit.
- match_count  output  CNT_W  saturating count of match pulses since the last reset or config write.
- cfg_err  output  1  one-cycle pulse; the config write was rejected.

## Operation
- Registers:
  - hist[MAX_LEN-1:0]: shift register, newest bit in [0].
  - fill: count of valid history bits, saturating at MAX_LEN.
  - pattern, len and mode.
  - armed, match and match_count.
- Accepted bit: in_valid=1, armed=1 and cfg_we=0. Then hist <= {hist[MAX_LEN-2:0], in_bit} and fill increments (saturating). Bits arriving while unarmed or during a config write are dropped.
- Hit: an accepted bit for which the updated fill is >= len and the updated hist[len-1:0] equals pattern[len-1:0]. Bits at or above len are ignored in both operands.
- Effect of a hit by mode:
  - MODE_OVERLAP: history is kept, so the tail of a match may start the next one.
  - MODE_RESTART: fill is cleared to 0 in the same update. The next match needs len fresh bits.
  - MODE_ONESHOT: fill is cleared and armed goes to 0. armed stays 0 until rst or a valid cfg_we.
- Every hit sets match=1 for the next cycle and increments match_count, which saturates at 2^CNT_W-1 with no wrap.
- Config write, valid when 1 <= cfg_len <= MAX_LEN:
  - pattern, len and mode are loaded.
  - fill, match and match_count are cleared; armed is set to 1.
  - hist contents become don't-care, because fill gates them.
- Config write with cfg_len of 0 or greater than MAX_LEN: no register changes, and cfg_err pulses for one cycle.
- cfg_mode value 2'b11 is treated as MODE_RESTART.
- Reset values:
  - pattern = all ones, len = 5, mode = MODE_RESTART.
  - fill = 0, hist = 0.
  - match = 0, armed = 1, match_count = 0, cfg_err = 0.

## Timing
- Latency: the bit that completes a hit is sampled at edge N. match is high from edge N until edge N+1. match_count shows the new value from edge N.
- There is no throughput limit: back-to-back hits in MODE_OVERLAP produce match high on consecutive cycles.
- Simultaneous cfg_we and in_valid: the configuration wins, the bit is dropped, and match is 0 next cycle.
- rst asserted in the middle of a partial pattern discards it. The first post-reset match needs 5 fresh 1s.
- A valid config write takes effect on the next accepted bit. A rejected write leaves detection running unchanged.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- pattern_detector_pkg holds:
  - match_mode_t, a 2-bit enum;
  - the function len_w(max_len) returning $clog2(max_len+1);
  - the reset constants RST_LEN = 5 and RST_MODE = MODE_RESTART.
- One sub-module, sat_counter #(W): synchronous clear, increment enable, saturation. It is instantiated for match_count.
- The masked compare is combinational inside pattern_detector: mask = (1 << len) - 1.

## Test plan
- Reset defaults: apply rst, then send 1,1,1,1,1 valid. Required: match at the cycle after the 5th bit, match_count=1. A 6th bit of 1 gives no match; bits 6-10 all 1 give a second match.
- Overlap: configure pattern=3'b101, len=3, MODE_OVERLAP, then send 1,0,1,0,1. Required: match after bits 3 and 5, match_count=2. The same stimulus in MODE_RESTART gives a single match after bit 3.
- One-shot: configure 4'b1100, len=4, MODE_ONESHOT, then send 1,1,0,0,1,1,0,0. Required: one match, armed=0 after it, match_count=1. A following valid cfg_we brings armed back to 1.
- Gaps and collisions: send pattern 101 with in_valid low on alternate cycles. Required: match after the 3rd accepted bit only. Asserting cfg_we together with the 3rd bit gives no match and match_count=0.
- Bad config: cfg_len=0, then cfg_len=MAX_LEN+1. Required: a cfg_err pulse for each, with pattern, len, mode and count unchanged. A full-length pattern of alternating 1s and 0s at len=MAX_LEN still matches.
- Saturation: with CNT_W=2, MODE_OVERLAP, pattern=1 and len=1, send 6 ones. Required: match high for 6 consecutive cycles and match_count stops at 3.
